// File: rtl/a2d_cond_pkg.sv
// Shared word type, thresholds and battery FSM encoding for the A2D conditioner.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package a2d_cond_pkg;

  typedef logic [11:0] adc_word_t;

  localparam adc_word_t BATT_LOW_TH = 12'hA98;
  localparam adc_word_t BATT_HYST   = 12'h040;
  localparam adc_word_t BRAKE_TH    = 12'h800;

  // Battery must climb back to this level before batt_low is released.
  localparam adc_word_t BATT_OK_TH  = BATT_LOW_TH + BATT_HYST;

  typedef enum logic {
    BATT_OK  = 1'b0,
    BATT_LOW = 1'b1
  } batt_state_t;

endpackage

// File: rtl/exp_avg.sv
// Exponential moving average over a 2^K-sample window, updated on each sample strobe.
// Latency: avg reflects a sample 1 clock after the strobe that captured it.
// Backpressure: none; consumes one word per strobe unconditionally.
module exp_avg
  import a2d_cond_pkg::*;
#(
  parameter int K = 2  // window shift, must be >= 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      smpl,
  input  logic      primed,
  input  adc_word_t din,
  output adc_word_t avg
);

  localparam int AW = 12 + K;

  logic [AW-1:0] acc;
  logic [AW-1:0] din_ext;

  assign din_ext = {{K{1'b0}}, din};

  // First sample seeds the accumulator so the average starts at the sample itself;
  // afterwards leak 1/2^K of the history and add the new sample (bounded by 0xFFF<<K).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (smpl) begin
      if (!primed) acc <= din_ext << K;
      else         acc <= acc - (acc >> K) + din_ext;
    end
  end

  assign avg = acc[AW-1:K];

endmodule

// File: rtl/a2d_conditioner.sv
// Conditions raw A2D words: averaged curr/torque, debounced hysteretic batt_low, qualified brake.
// Latency: inputs captured at the edge ending the smpl cycle; all outputs update 1 clock later.
// Backpressure: none; sampling is paced by the internal SMPL_PER timer only.
module a2d_conditioner
  import a2d_cond_pkg::*;
#(
  parameter int SMPL_PER = 4096,
  parameter int CURR_K   = 2,
  parameter int TORQUE_K = 4,
  parameter int LOW_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic [11:0] brake,
  output logic        smpl,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        batt_low,
  output logic        brake_on,
  output logic        valid
);

  localparam int TW = (SMPL_PER > 2) ? $clog2(SMPL_PER) : 1;
  localparam int CW = $clog2(LOW_CNT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(SMPL_PER - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOW_CNT);

  logic [TW-1:0] tmr;
  batt_state_t   batt_state, batt_state_nxt;
  logic [CW-1:0] low_cnt, low_cnt_nxt;
  logic          brake_prev_low;
  logic          brake_cur_low;

  // Free-running sample timer, 0..SMPL_PER-1.
  always_ff @(posedge clk) begin
    if (!rst_n)               tmr <= '0;
    else if (tmr == TMR_LAST) tmr <= '0;
    else                      tmr <= tmr + TW'(1);
  end

  assign smpl = (tmr == TMR_LAST);

  // Averages are primed by the first strobe after reset; valid doubles as the primed flag.
  always_ff @(posedge clk) begin
    if (!rst_n)    valid <= 1'b0;
    else if (smpl) valid <= 1'b1;
  end

  exp_avg #(.K(CURR_K)) u_avg_curr (
    .clk    (clk),
    .rst_n  (rst_n),
    .smpl   (smpl),
    .primed (valid),
    .din    (curr),
    .avg    (avg_curr)
  );

  exp_avg #(.K(TORQUE_K)) u_avg_torque (
    .clk    (clk),
    .rst_n  (rst_n),
    .smpl   (smpl),
    .primed (valid),
    .din    (torque),
    .avg    (avg_torque)
  );

  // Battery state and debounce counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      batt_state <= BATT_OK;
      low_cnt    <= '0;
    end else begin
      batt_state <= batt_state_nxt;
      low_cnt    <= low_cnt_nxt;
    end
  end

  // Battery next state: debounce entry into LOW, hysteretic exit; band samples hold.
  always_comb begin
    batt_state_nxt = batt_state;
    low_cnt_nxt    = low_cnt;
    if (smpl) begin
      case (batt_state)
        BATT_OK: begin
          if (batt < BATT_LOW_TH) begin
            if (low_cnt != CNT_MAX) low_cnt_nxt = low_cnt + CW'(1);
            if (low_cnt >= CNT_MAX - CW'(1)) batt_state_nxt = BATT_LOW;
          end else begin
            low_cnt_nxt = '0;
          end
        end
        BATT_LOW: begin
          if (batt >= BATT_OK_TH) begin
            batt_state_nxt = BATT_OK;
            low_cnt_nxt    = '0;
          end
        end
        default: begin
          batt_state_nxt = BATT_OK;
          low_cnt_nxt    = '0;
        end
      endcase
    end
  end

  assign batt_low = (batt_state == BATT_LOW);

  assign brake_cur_low = (brake < BRAKE_TH);

  // Brake changes state only after two agreeing consecutive samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brake_prev_low <= 1'b0;
      brake_on       <= 1'b0;
    end else if (smpl) begin
      brake_prev_low <= brake_cur_low;
      if (brake_cur_low && brake_prev_low)        brake_on <= 1'b1;
      else if (!brake_cur_low && !brake_prev_low) brake_on <= 1'b0;
    end
  end

endmodule

// File: tb/tb_a2d_conditioner.sv
module tb_a2d_conditioner;

  localparam int PER = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt = '0, curr = '0, torque = '0, brake = '0;
  logic        smpl, batt_low, brake_on, valid;
  logic [11:0] avg_curr, avg_torque;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: scaled averages (avg * 2^K), low-batt run length, brake history.
  int m_acc_c, m_acc_t, m_run, m_nsmp;
  bit m_primed, m_low, m_brk_on, m_prev_brk_low;

  always #5 clk = ~clk;

  a2d_conditioner #(.SMPL_PER(PER), .CURR_K(2), .TORQUE_K(4), .LOW_CNT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .batt       (batt),
    .curr       (curr),
    .torque     (torque),
    .brake      (brake),
    .smpl       (smpl),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .batt_low   (batt_low),
    .brake_on   (brake_on),
    .valid      (valid)
  );

  function automatic logic [11:0] exp_curr();
    return 12'(m_acc_c / 4);
  endfunction

  function automatic logic [11:0] exp_torque();
    return 12'(m_acc_t / 16);
  endfunction

  task automatic model_reset();
    m_acc_c = 0; m_acc_t = 0; m_run = 0; m_nsmp = 0;
    m_primed = 0; m_low = 0; m_brk_on = 0; m_prev_brk_low = 0;
  endtask

  task automatic model_sample(input logic [11:0] b, c, t, br);
    bit lo;
    if (!m_primed) begin
      m_acc_c = int'(c) * 4;
      m_acc_t = int'(t) * 16;
      m_primed = 1;
    end else begin
      m_acc_c = m_acc_c - m_acc_c / 4 + int'(c);
      m_acc_t = m_acc_t - m_acc_t / 16 + int'(t);
    end
    if (m_low) begin
      if (int'(b) >= 'hAD8) begin m_low = 0; m_run = 0; end
    end else begin
      if (int'(b) < 'hA98) m_run++; else m_run = 0;
      if (m_run >= 3) m_low = 1;
    end
    lo = (int'(br) < 'h800);
    if (m_nsmp >= 1 && lo && m_prev_brk_low) m_brk_on = 1;
    else if (m_nsmp >= 1 && !lo && !m_prev_brk_low) m_brk_on = 0;
    m_prev_brk_low = lo;
    m_nsmp++;
  endtask

  // Wait for a strobe, scribbling random values on the inputs in every non-strobe cycle.
  task automatic wait_strobe();
    bit ok = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      @(posedge clk); #1;
      if (smpl) begin ok = 1; break; end
      batt = 12'($urandom); curr = 12'($urandom);
      torque = 12'($urandom); brake = 12'($urandom);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_timeout: smpl not seen within %0d clocks", 3 * PER);
    end
  endtask

  task automatic drive_and_capture(input logic [11:0] b, c, t, br);
    batt = b; curr = c; torque = t; brake = br;
    @(posedge clk); #1;
    model_sample(b, c, t, br);
  endtask

  task automatic apply(input logic [11:0] b, c, t, br);
    wait_strobe();
    drive_and_capture(b, c, t, br);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int n = 0;
    logic [11:0] t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({smpl, avg_curr, avg_torque, batt_low, brake_on, valid} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got smpl=%b ac=%h at=%h bl=%b bo=%b v=%b, want all 0",
               smpl, avg_curr, avg_torque, batt_low, brake_on, valid);
    end
    rst_n = 1'b1;
    model_reset();
    // Release happens mid-cycle; the strobe occupies the 16th clock period from that point.
    for (int i = 0; i < 3 * PER; i++) begin
      @(posedge clk); #1;
      n++;
      if (smpl) break;
    end
    n_cmp++;
    if (n !== PER - 1 || smpl !== 1'b1) begin
      n_bad++;
      $display("FAIL first_smpl: strobe after %0d edges (smpl=%b), want %0d", n, smpl, PER - 1);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL valid_before_prime: got %b want 0", valid);
    end
    t = 12'($urandom);
    drive_and_capture(12'hC00, 12'h400, t, 12'hFFF);
    n_cmp++;
    if (valid !== 1'b1 || smpl !== 1'b0) begin
      n_bad++; $display("FAIL valid_after_prime: got valid=%b smpl=%b want 1/0", valid, smpl);
    end
    n_cmp++;
    if (avg_curr !== 12'h400 || avg_torque !== t) begin
      n_bad++;
      $display("FAIL prime_avg: got ac=%h at=%h want 400/%h", avg_curr, avg_torque, t);
    end
  endtask

  task automatic test_curr_step();
    logic [11:0] want [3] = '{12'h500, 12'h5C0, 12'h650};
    for (int i = 0; i < 3; i++) begin
      apply(12'hC00, 12'h800, 12'($urandom), 12'hFFF);
      n_cmp++;
      if (avg_curr !== want[i] || avg_curr !== exp_curr()) begin
        n_bad++;
        $display("FAIL curr_step[%0d]: got %h want %h (model %h)", i, avg_curr, want[i], exp_curr());
      end
    end
  endtask

  task automatic test_batt();
    logic [11:0] bv [8] = '{12'hA97, 12'hA97, 12'hC00, 12'hA97, 12'hA97, 12'hA97, 12'hAC0, 12'hAD8};
    logic        bl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      apply(bv[i], 12'($urandom), 12'($urandom), 12'hFFF);
      n_cmp++;
      if (batt_low !== bl[i] || batt_low !== m_low) begin
        n_bad++;
        $display("FAIL batt_low[%0d] batt=%h: got %b want %b (model %b)", i, bv[i], batt_low, bl[i], m_low);
      end
    end
  endtask

  task automatic test_brake();
    logic [11:0] bv [9] = '{12'h100, 12'hFFF, 12'hFFF, 12'h100, 12'h100,
                            12'hFFF, 12'h100, 12'hFFF, 12'hFFF};
    logic        bo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      apply(12'hC00, 12'($urandom), 12'($urandom), bv[i]);
      n_cmp++;
      if (brake_on !== bo[i] || brake_on !== m_brk_on) begin
        n_bad++;
        $display("FAIL brake_on[%0d] brake=%h: got %b want %b (model %b)", i, bv[i], brake_on, bo[i], m_brk_on);
      end
    end
  endtask

  task automatic test_torque();
    logic [11:0] prev;
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      apply(12'hC00, 12'h400, 12'hFFF, 12'hFFF);
      n_cmp++;
      if (avg_torque !== exp_torque()) begin
        n_bad++; $display("FAIL torque_full[%0d]: got %h want %h", i, avg_torque, exp_torque());
      end
    end
    n_cmp++;
    if (avg_torque !== 12'hFFF) begin
      n_bad++; $display("FAIL torque_sat: got %h want fff", avg_torque);
    end
    prev = avg_torque;
    for (int i = 0; i < 16; i++) begin
      apply(12'hC00, 12'h400, 12'h000, 12'hFFF);
      n_cmp++;
      if (avg_torque !== exp_torque() || avg_torque >= prev) begin
        n_bad++;
        $display("FAIL torque_fall[%0d]: got %h prev %h want %h", i, avg_torque, prev, exp_torque());
      end
      prev = avg_torque;
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] c, t;
    apply(12'hA00, 12'($urandom), 12'($urandom), 12'h100);
    apply(12'hA00, 12'($urandom), 12'($urandom), 12'h100);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({smpl, avg_curr, avg_torque, batt_low, brake_on, valid} !== 28'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got smpl=%b ac=%h at=%h bl=%b bo=%b v=%b, want all 0",
               smpl, avg_curr, avg_torque, batt_low, brake_on, valid);
    end
    rst_n = 1'b1;
    model_reset();
    c = 12'($urandom); t = 12'($urandom);
    apply(12'hC00, c, t, 12'hFFF);
    n_cmp++;
    if (avg_curr !== c || avg_torque !== t || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reprime: got ac=%h at=%h v=%b want %h/%h/1", avg_curr, avg_torque, valid, c, t);
    end
  endtask

  task automatic test_random();
    logic [11:0] b, br;
    for (int i = 0; i < 60; i++) begin
      b  = 12'($urandom_range('hA60, 'hB00));
      br = ($urandom_range(0, 2) != 0) ? 12'($urandom_range(0, 'h7FF)) : 12'($urandom_range('h800, 'hFFF));
      apply(b, 12'($urandom), 12'($urandom), br);
      n_cmp++;
      if (avg_curr !== exp_curr()) begin
        n_bad++; $display("FAIL rnd_curr[%0d]: got %h want %h", i, avg_curr, exp_curr());
      end
      n_cmp++;
      if (avg_torque !== exp_torque()) begin
        n_bad++; $display("FAIL rnd_torque[%0d]: got %h want %h", i, avg_torque, exp_torque());
      end
      n_cmp++;
      if (batt_low !== m_low) begin
        n_bad++; $display("FAIL rnd_batt_low[%0d]: got %b want %b", i, batt_low, m_low);
      end
      n_cmp++;
      if (brake_on !== m_brk_on) begin
        n_bad++; $display("FAIL rnd_brake_on[%0d]: got %b want %b", i, brake_on, m_brk_on);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_curr_step();
    test_batt();
    test_brake();
    test_torque();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
